// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control in front of an asynchronous instruction ROM.
// Issues instructions to decode over valid/ready, applies redirects, halts on a halt word or bad PC.
module pc_fetch_unit #(
  parameter int unsigned             ADDR_W      = 32,
  parameter int unsigned             INST_W      = 32,
  parameter int unsigned             MEM_DEPTH   = 100,
  parameter logic [ADDR_W-1:0]       RESET_PC    = '0,
  parameter logic [INST_W-1:0]       HALT_OPCODE = 32'hFFFF_FFFF,
  parameter int unsigned             CNT_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [ADDR_W-1:0] Instr_Add,
  input  logic [INST_W-1:0] Instr_RD,
  output logic [INST_W-1:0] Dec_Instr,
  output logic [ADDR_W-1:0] Dec_PCPlus4,
  output logic              Dec_Valid,
  input  logic              Dec_Ready,
  input  logic              Br_Taken,
  input  logic [15:0]       Br_Imm,
  input  logic              Jmp,
  input  logic [25:0]       Jmp_Idx,
  input  logic              Jr,
  input  logic [ADDR_W-1:0] Jr_Target,
  input  logic              Resume,
  output logic              Halted,
  output logic              Fault,
  output logic [CNT_W-1:0]  Issue_Cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_HALT
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH * 4 - 4);

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_d;
  logic [ADDR_W-1:0]   pc_plus4;
  logic [ADDR_W-1:0]   br_off;
  logic [CNT_W-1:0]    cnt_q;
  logic                fault_q;
  logic                addr_ok;
  logic                is_halt;

  assign pc_plus4    = pc_q + ADDR_W'(4);
  assign br_off      = {{(ADDR_W-18){Br_Imm[15]}}, Br_Imm, 2'b00};
  assign addr_ok     = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_ADDR);
  assign is_halt     = (Instr_RD == HALT_OPCODE);

  assign Instr_Add   = pc_q;
  assign Dec_Instr   = Instr_RD;
  assign Dec_PCPlus4 = pc_plus4;
  assign Halted      = (state_q == ST_HALT);
  assign Fault       = fault_q;
  assign Issue_Cnt   = cnt_q;

  // A stalled instruction was already qualified in RUN and the PC has not moved since.
  assign Dec_Valid = RST && ((state_q == ST_STALL) ||
                             ((state_q == ST_RUN) && addr_ok && !is_halt));

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    pc_d = pc_plus4;
    if (Jr) begin
      pc_d = Jr_Target;
    end else if (Jmp) begin
      pc_d = {pc_plus4[ADDR_W-1:28], Jmp_Idx, 2'b00};
    end else if (Br_Taken) begin
      pc_d = pc_plus4 + br_off;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!addr_ok) begin
            state_q <= ST_HALT;
            fault_q <= 1'b1;
          end else if (is_halt) begin
            state_q <= ST_HALT;
            fault_q <= 1'b0;
          end else if (Dec_Ready) begin
            pc_q  <= pc_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (Dec_Ready) begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= ST_RUN;
          end
        end
        ST_HALT: begin
          if (Resume) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural ROM; counter width narrowed to 4 to reach wrap quickly.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] Instr_Add;
  logic [31:0] Instr_RD;
  logic [31:0] Dec_Instr;
  logic [31:0] Dec_PCPlus4;
  logic        Dec_Valid;
  logic        Dec_Ready = 1'b1;
  logic        Br_Taken = 1'b0;
  logic [15:0] Br_Imm = '0;
  logic        Jmp = 1'b0;
  logic [25:0] Jmp_Idx = '0;
  logic        Jr = 1'b0;
  logic [31:0] Jr_Target = '0;
  logic        Resume = 1'b0;
  logic        Halted;
  logic        Fault;
  logic [3:0]  Issue_Cnt;

  logic [31:0] rom [0:127];
  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  assign Instr_RD = (Instr_Add < 32'd400) ? rom[Instr_Add[8:2]] : 32'h0000_0000;

  pc_fetch_unit #(.CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .Instr_Add(Instr_Add), .Instr_RD(Instr_RD),
    .Dec_Instr(Dec_Instr), .Dec_PCPlus4(Dec_PCPlus4), .Dec_Valid(Dec_Valid),
    .Dec_Ready(Dec_Ready), .Br_Taken(Br_Taken), .Br_Imm(Br_Imm), .Jmp(Jmp),
    .Jmp_Idx(Jmp_Idx), .Jr(Jr), .Jr_Target(Jr_Target), .Resume(Resume),
    .Halted(Halted), .Fault(Fault), .Issue_Cnt(Issue_Cnt)
  );

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 128; i++) rom[i] = 32'h2000_0000 | i;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    Dec_Ready = 1'b1; Br_Taken = 1'b0; Jmp = 1'b0; Jr = 1'b0; Resume = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    fill_rom();
    #1;
    vectors++; if (Instr_Add !== 32'd0) begin miscompares++; $display("FAIL reset_pc: got %0d want 0", Instr_Add); end
    vectors++; if (Dec_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", Dec_Valid); end
    vectors++; if (Halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", Halted); end
    vectors++; if (Fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", Fault); end
    vectors++; if (Issue_Cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", Issue_Cnt); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_word;
    fill_rom();
    for (int i = 0; i < 4; i++) rom[i] = 32'h0022_1820 + i;
    rom[4] = 32'hFFFF_FFFF;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_word = 32'h0022_1820 + i;
      vectors++; if (Instr_Add !== 32'(4*i)) begin miscompares++; $display("FAIL seq_addr[%0d]: got %0d want %0d", i, Instr_Add, 4*i); end
      vectors++; if (Dec_Valid !== 1'b1) begin miscompares++; $display("FAIL seq_valid[%0d]: got %b want 1", i, Dec_Valid); end
      vectors++; if (Dec_Instr !== exp_word) begin miscompares++; $display("FAIL seq_instr[%0d]: got %h want %h", i, Dec_Instr, exp_word); end
      vectors++; if (Dec_PCPlus4 !== 32'(4*i+4)) begin miscompares++; $display("FAIL seq_pc4[%0d]: got %0d want %0d", i, Dec_PCPlus4, 4*i+4); end
      tick();
    end
    vectors++; if (Instr_Add !== 32'd16) begin miscompares++; $display("FAIL seq_halt_addr: got %0d want 16", Instr_Add); end
    vectors++; if (Dec_Valid !== 1'b0) begin miscompares++; $display("FAIL seq_halt_valid: got %b want 0", Dec_Valid); end
    tick();
    vectors++; if (Halted !== 1'b1) begin miscompares++; $display("FAIL seq_halted: got %b want 1", Halted); end
    vectors++; if (Fault !== 1'b0) begin miscompares++; $display("FAIL seq_fault: got %b want 0", Fault); end
    vectors++; if (Issue_Cnt !== 4'd4) begin miscompares++; $display("FAIL seq_cnt: got %0d want 4", Issue_Cnt); end
    vectors++; if (Instr_Add !== 32'd16) begin miscompares++; $display("FAIL seq_hold_addr: got %0d want 16", Instr_Add); end
  endtask

  task automatic test_stall();
    fill_rom();
    do_reset();
    tick(); tick();
    Dec_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (Instr_Add !== 32'd8) begin miscompares++; $display("FAIL stall_addr[%0d]: got %0d want 8", i, Instr_Add); end
      vectors++; if (Dec_Valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 1", i, Dec_Valid); end
      vectors++; if (Dec_Instr !== 32'h2000_0002) begin miscompares++; $display("FAIL stall_instr[%0d]: got %h want 20000002", i, Dec_Instr); end
      vectors++; if (Issue_Cnt !== 4'd2) begin miscompares++; $display("FAIL stall_cnt[%0d]: got %0d want 2", i, Issue_Cnt); end
    end
    Dec_Ready = 1'b1;
    tick();
    vectors++; if (Instr_Add !== 32'd12) begin miscompares++; $display("FAIL stall_release_addr: got %0d want 12", Instr_Add); end
    vectors++; if (Issue_Cnt !== 4'd3) begin miscompares++; $display("FAIL stall_release_cnt: got %0d want 3", Issue_Cnt); end
  endtask

  task automatic test_redirect();
    fill_rom();
    do_reset();
    tick(); tick();
    Br_Taken = 1'b1; Br_Imm = 16'hFFFE;
    tick();
    Br_Taken = 1'b0;
    vectors++; if (Instr_Add !== 32'd4) begin miscompares++; $display("FAIL branch_back: got %0d want 4", Instr_Add); end
    Jmp = 1'b1; Jmp_Idx = 26'd5;
    tick();
    Jmp = 1'b0;
    vectors++; if (Instr_Add !== 32'd20) begin miscompares++; $display("FAIL jump_idx5: got %0d want 20", Instr_Add); end
    Dec_Ready = 1'b0; Jr = 1'b1; Jr_Target = 32'd40;
    tick();
    vectors++; if (Instr_Add !== 32'd20) begin miscompares++; $display("FAIL redirect_no_accept: got %0d want 20", Instr_Add); end
    Jmp = 1'b1; Br_Taken = 1'b1; Br_Imm = 16'h0003; Dec_Ready = 1'b1;
    tick();
    Jr = 1'b0; Jmp = 1'b0; Br_Taken = 1'b0;
    vectors++; if (Instr_Add !== 32'd40) begin miscompares++; $display("FAIL redirect_priority: got %0d want 40", Instr_Add); end
    vectors++; if (Issue_Cnt !== 4'd5) begin miscompares++; $display("FAIL redirect_cnt: got %0d want 5", Issue_Cnt); end
  endtask

  task automatic test_fault();
    fill_rom();
    do_reset();
    Jr = 1'b1; Jr_Target = 32'd400;
    tick();
    Jr = 1'b0;
    vectors++; if (Instr_Add !== 32'd400) begin miscompares++; $display("FAIL fault_oor_addr: got %0d want 400", Instr_Add); end
    vectors++; if (Dec_Valid !== 1'b0) begin miscompares++; $display("FAIL fault_oor_valid: got %b want 0", Dec_Valid); end
    tick();
    vectors++; if (Halted !== 1'b1) begin miscompares++; $display("FAIL fault_oor_halted: got %b want 1", Halted); end
    vectors++; if (Fault !== 1'b1) begin miscompares++; $display("FAIL fault_oor_fault: got %b want 1", Fault); end
    tick();
    vectors++; if (Instr_Add !== 32'd400) begin miscompares++; $display("FAIL fault_hold_addr: got %0d want 400", Instr_Add); end
    Resume = 1'b1;
    tick();
    Resume = 1'b0;
    vectors++; if (Instr_Add !== 32'd0) begin miscompares++; $display("FAIL resume_addr: got %0d want 0", Instr_Add); end
    vectors++; if (Fault !== 1'b0) begin miscompares++; $display("FAIL resume_fault: got %b want 0", Fault); end
    vectors++; if (Halted !== 1'b0) begin miscompares++; $display("FAIL resume_halted: got %b want 0", Halted); end
    vectors++; if (Issue_Cnt !== 4'd1) begin miscompares++; $display("FAIL resume_cnt_kept: got %0d want 1", Issue_Cnt); end
    Jr = 1'b1; Jr_Target = 32'd6;
    tick();
    Jr = 1'b0;
    tick();
    vectors++; if (Halted !== 1'b1 || Fault !== 1'b1) begin miscompares++; $display("FAIL fault_misaligned: got halted=%b fault=%b want 1 1", Halted, Fault); end
    vectors++; if (Instr_Add !== 32'd6) begin miscompares++; $display("FAIL fault_misaligned_addr: got %0d want 6", Instr_Add); end
    Resume = 1'b1;
    tick();
    tick();
    vectors++; if (Instr_Add !== 32'd4) begin miscompares++; $display("FAIL resume_in_run_ignored: got %0d want 4", Instr_Add); end
    Resume = 1'b0;
    vectors++; if (Issue_Cnt !== 4'd3) begin miscompares++; $display("FAIL fault_final_cnt: got %0d want 3", Issue_Cnt); end
  endtask

  task automatic test_async_reset();
    fill_rom();
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    Dec_Ready = 1'b0;
    tick();
    vectors++; if (Instr_Add !== 32'd24 || Dec_Valid !== 1'b1) begin miscompares++; $display("FAIL areset_pre: got addr=%0d valid=%b want 24 1", Instr_Add, Dec_Valid); end
    #2;
    RST = 1'b0;
    #1;
    vectors++; if (Instr_Add !== 32'd0) begin miscompares++; $display("FAIL areset_addr: got %0d want 0", Instr_Add); end
    vectors++; if (Issue_Cnt !== 4'd0) begin miscompares++; $display("FAIL areset_cnt: got %0d want 0", Issue_Cnt); end
    vectors++; if (Dec_Valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid: got %b want 0", Dec_Valid); end
    @(negedge CLK);
    RST = 1'b1; Dec_Ready = 1'b1;
    #1;
    vectors++; if (Dec_Valid !== 1'b1) begin miscompares++; $display("FAIL areset_release_valid: got %b want 1", Dec_Valid); end
    tick();
    vectors++; if (Instr_Add !== 32'd4 || Issue_Cnt !== 4'd1) begin miscompares++; $display("FAIL areset_first_fetch: got addr=%0d cnt=%0d want 4 1", Instr_Add, Issue_Cnt); end
  endtask

  task automatic test_counter_wrap();
    fill_rom();
    do_reset();
    for (int i = 0; i < 17; i++) tick();
    vectors++; if (Issue_Cnt !== 4'd1) begin miscompares++; $display("FAIL cnt_wrap: got %0d want 1", Issue_Cnt); end
    vectors++; if (Instr_Add !== 32'd68) begin miscompares++; $display("FAIL cnt_wrap_addr: got %0d want 68", Instr_Add); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fault();
    test_async_reset();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
